// File: rtl/join_store_stage.sv
// -----------------------------------------------------------------------------
// join_store_stage
//
// Terminal stage of the dataflow pipeline. Each invocation pops N_ELEM element
// pairs from FIFO D and FIFO E, adds each pair and writes the sum to RAM F at
// addresses 0..N_ELEM-1 through a single-port write interface. Invocations are
// controlled by the ap_ctrl handshake.
//
// Optional feature (compile-time macro JOIN_STORE_SAT_EN):
//   defined   - sums saturate as signed DATA_W-bit values and ovf_flag is a
//               sticky indicator of any saturating write since the last
//               accepted ap_start.
//   undefined - sums wrap modulo 2^DATA_W and ovf_flag is tied low.
//
// Ports:
//   ap_clk, ap_rst_n        clock (rising edge), async active-low reset
//   ap_start                start request (sampled in IDLE only)
//   ap_continue             permission to leave DONE
//   ap_done/ap_idle/ap_ready  handshake status
//   D_dout, D_empty_n, D_read  FIFO D head / non-empty / pop
//   E_dout, E_empty_n, E_read  FIFO E head / non-empty / pop
//   F_address0, F_ce0, F_we0, F_d0  RAM F write port
//   ovf_flag                sticky saturation indicator
//
// States:
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for ap_start, ap_idle high
//   RUN     | consuming pairs; one write per cycle both FIFOs have data
//   DONE    | ap_done high until ap_continue is seen
// -----------------------------------------------------------------------------
module join_store_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3,
    parameter int N_ELEM = 8
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    input  logic              ap_continue,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    input  logic [DATA_W-1:0] D_dout,
    input  logic              D_empty_n,
    output logic              D_read,
    input  logic [DATA_W-1:0] E_dout,
    input  logic              E_empty_n,
    output logic              E_read,
    output logic [ADDR_W-1:0] F_address0,
    output logic              F_ce0,
    output logic              F_we0,
    output logic [DATA_W-1:0] F_d0,
    output logic              ovf_flag
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_ELEM - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              fire;
    logic              last_elem;
    logic [DATA_W-1:0] sum_wrap;
    logic [DATA_W-1:0] sum;

    // A pair is consumed only when both heads are valid, so the two FIFOs
    // always advance together.
    assign fire      = (state_q == ST_RUN) & D_empty_n & E_empty_n;
    assign last_elem = (idx_q == LAST_IDX);
    assign sum_wrap  = D_dout + E_dout;

`ifdef JOIN_STORE_SAT_EN
    logic ovf_q, ovf_d;
    logic pos_ovf, neg_ovf;

    // Signed overflow: operands share a sign that the wrapped result lacks.
    always_comb begin
        pos_ovf = ~D_dout[DATA_W-1] & ~E_dout[DATA_W-1] &  sum_wrap[DATA_W-1];
        neg_ovf =  D_dout[DATA_W-1] &  E_dout[DATA_W-1] & ~sum_wrap[DATA_W-1];
        if (pos_ovf) begin
            sum = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (neg_ovf) begin
            sum = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            sum = sum_wrap;
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if ((state_q == ST_IDLE) && ap_start) begin
            ovf_d = 1'b0;
        end else if (fire && (pos_ovf || neg_ovf)) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_flag = ovf_q;
`else
    assign sum      = sum_wrap;
    assign ovf_flag = 1'b0;
`endif

    // State register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (ap_start) begin
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (fire) begin
                    if (last_elem) begin
                        idx_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end
            end
            ST_DONE: begin
                if (ap_continue) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                idx_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs. Address and data are forced to zero when the RAM is not
    // enabled so the write port is quiet between writes.
    always_comb begin
        ap_idle    = (state_q == ST_IDLE);
        ap_done    = (state_q == ST_DONE);
        ap_ready   = fire & last_elem;
        D_read     = fire;
        E_read     = fire;
        F_ce0      = fire;
        F_we0      = fire;
        F_address0 = fire ? idx_q : '0;
        F_d0       = fire ? sum   : '0;
    end

endmodule

// File: tb/tb_join_store_stage.sv
module tb_join_store_stage;

    localparam int N = 8;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        ap_start;
    logic        ap_continue;
    logic        ap_done, ap_idle, ap_ready;
    logic [31:0] D_dout, E_dout;
    logic        D_empty_n, E_empty_n;
    logic        D_read, E_read;
    logic [2:0]  F_address0;
    logic        F_ce0, F_we0;
    logic [31:0] F_d0;
    logic        ovf_flag;

    int n_vec = 0;
    int n_err = 0;

    // FIFO models and per-cycle availability gates
    logic [31:0] D_q[$];
    logic [31:0] E_q[$];
    logic        d_gate, e_gate;

    // Outputs sampled on the falling edge of the last cycle
    logic        s_done, s_idle, s_ready, s_d_read, s_e_read, s_ce, s_we, s_ovf;
    logic [2:0]  s_addr;
    logic [31:0] s_d0;

    always #5 ap_clk = ~ap_clk;

    join_store_stage dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .ap_start    (ap_start),
        .ap_continue (ap_continue),
        .ap_done     (ap_done),
        .ap_idle     (ap_idle),
        .ap_ready    (ap_ready),
        .D_dout      (D_dout),
        .D_empty_n   (D_empty_n),
        .D_read      (D_read),
        .E_dout      (E_dout),
        .E_empty_n   (E_empty_n),
        .E_read      (E_read),
        .F_address0  (F_address0),
        .F_ce0       (F_ce0),
        .F_we0       (F_we0),
        .F_d0        (F_d0),
        .ovf_flag    (ovf_flag)
    );

    // Reference arithmetic: exact signed sum, then clamp or wrap to 32 bits.
    function automatic logic [31:0] exp_sum(input logic [31:0] a, input logic [31:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
`ifdef JOIN_STORE_SAT_EN
        if (s > SMAX) s = SMAX;
        else if (s < SMIN) s = SMIN;
`endif
        return s[31:0];
    endfunction

    function automatic logic exp_ovf(input logic [31:0] a, input logic [31:0] b);
`ifdef JOIN_STORE_SAT_EN
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
        return (s > SMAX) || (s < SMIN);
`else
        return 1'b0;
`endif
    endfunction

    // One clock cycle: present FIFO heads, sample outputs mid-cycle, pop the
    // FIFO models on read strobes, and return just after the next rising edge.
    task automatic cyc();
        D_dout    = (D_q.size() > 0) ? D_q[0] : 32'h0;
        E_dout    = (E_q.size() > 0) ? E_q[0] : 32'h0;
        D_empty_n = d_gate && (D_q.size() > 0);
        E_empty_n = e_gate && (E_q.size() > 0);
        @(negedge ap_clk);
        s_done = ap_done;  s_idle = ap_idle;  s_ready = ap_ready;
        s_d_read = D_read; s_e_read = E_read; s_ce = F_ce0; s_we = F_we0;
        s_addr = F_address0; s_d0 = F_d0; s_ovf = ovf_flag;
        if (D_read && D_q.size() > 0) void'(D_q.pop_front());
        if (E_read && E_q.size() > 0) void'(E_q.pop_front());
        @(posedge ap_clk);
        #1;
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0; ap_start = 1'b0; ap_continue = 1'b1;
        d_gate = 1'b1; e_gate = 1'b1;
        D_q.push_back(32'h1234); E_q.push_back(32'h5678);
        D_dout = 32'h1234; E_dout = 32'h5678; D_empty_n = 1'b1; E_empty_n = 1'b1;
        #1;
        n_vec++; if (ap_idle !== 1'b1) begin n_err++; $display("FAIL reset_idle_async: got %b want 1", ap_idle); end
        cyc();
        cyc();
        n_vec++; if (s_idle !== 1'b1)   begin n_err++; $display("FAIL reset_idle: got %b want 1", s_idle); end
        n_vec++; if (s_done !== 1'b0)   begin n_err++; $display("FAIL reset_done: got %b want 0", s_done); end
        n_vec++; if (s_ready !== 1'b0)  begin n_err++; $display("FAIL reset_ready: got %b want 0", s_ready); end
        n_vec++; if (s_d_read !== 1'b0) begin n_err++; $display("FAIL reset_d_read: got %b want 0", s_d_read); end
        n_vec++; if (s_e_read !== 1'b0) begin n_err++; $display("FAIL reset_e_read: got %b want 0", s_e_read); end
        n_vec++; if (s_ce !== 1'b0)     begin n_err++; $display("FAIL reset_ce: got %b want 0", s_ce); end
        n_vec++; if (s_we !== 1'b0)     begin n_err++; $display("FAIL reset_we: got %b want 0", s_we); end
        n_vec++; if (s_addr !== 3'd0)   begin n_err++; $display("FAIL reset_addr: got %0d want 0", s_addr); end
        n_vec++; if (s_d0 !== 32'h0)    begin n_err++; $display("FAIL reset_d0: got %h want 0", s_d0); end
        n_vec++; if (s_ovf !== 1'b0)    begin n_err++; $display("FAIL reset_ovf: got %b want 0", s_ovf); end
        ap_rst_n = 1'b1;
        cyc();
        n_vec++; if (s_idle !== 1'b1 || s_d_read !== 1'b0)
            begin n_err++; $display("FAIL post_reset_idle: idle=%b read=%b want idle=1 read=0", s_idle, s_d_read); end
        D_q.delete(); E_q.delete();
    endtask

    task automatic test_preload();
        for (int i = 0; i < N; i++) begin
            D_q.push_back(32'(i)); E_q.push_back(32'(10 * i));
        end
        d_gate = 1'b1; e_gate = 1'b1; ap_continue = 1'b1;
        ap_start = 1'b1;
        cyc();
        n_vec++; if (s_idle !== 1'b1 || s_d_read !== 1'b0)
            begin n_err++; $display("FAIL preload_start: idle=%b read=%b want idle=1 read=0", s_idle, s_d_read); end
        ap_start = 1'b0;
        for (int i = 0; i < N; i++) begin
            cyc();
            n_vec++; if (s_we !== 1'b1 || s_ce !== 1'b1)
                begin n_err++; $display("FAIL preload_we[%0d]: we=%b ce=%b want 1", i, s_we, s_ce); end
            n_vec++; if (s_addr !== 3'(i))
                begin n_err++; $display("FAIL preload_addr[%0d]: got %0d want %0d", i, s_addr, i); end
            n_vec++; if (s_d0 !== 32'(11 * i))
                begin n_err++; $display("FAIL preload_data[%0d]: got %0d want %0d", i, s_d0, 11 * i); end
            n_vec++; if (s_ready !== (i == N - 1))
                begin n_err++; $display("FAIL preload_ready[%0d]: got %b want %b", i, s_ready, (i == N - 1)); end
            n_vec++; if (s_done !== 1'b0 || s_idle !== 1'b0)
                begin n_err++; $display("FAIL preload_run_status[%0d]: done=%b idle=%b want 0 0", i, s_done, s_idle); end
        end
        cyc();
        n_vec++; if (s_done !== 1'b1 || s_idle !== 1'b0 || s_ce !== 1'b0)
            begin n_err++; $display("FAIL preload_done: done=%b idle=%b ce=%b want 1 0 0", s_done, s_idle, s_ce); end
        cyc();
        n_vec++; if (s_done !== 1'b0 || s_idle !== 1'b1)
            begin n_err++; $display("FAIL preload_after_done: done=%b idle=%b want 0 1", s_done, s_idle); end
    endtask

    // mode 0: D always available, E every third cycle; mode 1: random gaps on both
    task automatic test_stream(input int mode, input int n_inv);
        logic [31:0] dv[N];
        logic [31:0] ev[N];
        int k, t, phase;
        logic exp_fire, seen_done;
        for (int inv = 0; inv < n_inv; inv++) begin
            for (int i = 0; i < N; i++) begin
                dv[i] = $urandom; ev[i] = $urandom;
                D_q.push_back(dv[i]); E_q.push_back(ev[i]);
            end
            d_gate = 1'b1; e_gate = 1'b1;
            ap_start = 1'b1;
            cyc();
            n_vec++; if (s_d_read !== 1'b0)
                begin n_err++; $display("FAIL stream%0d_idle_read: got %b want 0", mode, s_d_read); end
            ap_start = 1'b0;
            k = 0; t = 0; phase = 0; seen_done = 1'b0;
            while (!seen_done && t < 200) begin
                if (mode == 0) begin
                    d_gate = 1'b1; e_gate = (t % 3 == 0);
                end else begin
                    d_gate = 1'($urandom_range(0, 1)); e_gate = 1'($urandom_range(0, 1));
                end
                exp_fire = (phase == 0) && d_gate && e_gate;
                cyc();
                n_vec++; if (s_d_read !== s_e_read)
                    begin n_err++; $display("FAIL stream%0d_pair_read t=%0d: D_read=%b E_read=%b", mode, t, s_d_read, s_e_read); end
                n_vec++; if (s_d_read !== exp_fire || s_we !== exp_fire)
                    begin n_err++; $display("FAIL stream%0d_fire t=%0d: read=%b we=%b want %b", mode, t, s_d_read, s_we, exp_fire); end
                if (phase == 1) begin
                    n_vec++; if (s_done !== 1'b1)
                        begin n_err++; $display("FAIL stream%0d_done: got %b want 1", mode, s_done); end
                    seen_done = 1'b1;
                end else begin
                    n_vec++; if (s_ready !== (exp_fire && k == N - 1))
                        begin n_err++; $display("FAIL stream%0d_ready t=%0d: got %b want %b", mode, t, s_ready, (exp_fire && k == N - 1)); end
                    if (exp_fire) begin
                        n_vec++; if (s_addr !== 3'(k) || s_d0 !== exp_sum(dv[k], ev[k]))
                            begin n_err++; $display("FAIL stream%0d_write[%0d]: addr=%0d data=%h want addr=%0d data=%h", mode, k, s_addr, s_d0, k, exp_sum(dv[k], ev[k])); end
                        k++;
                        if (k == N) phase = 1;
                    end
                end
                t++;
            end
            if (!seen_done) begin
                n_vec++; n_err++;
                $display("FAIL stream%0d_timeout: writes=%0d want %0d, done not seen", mode, k, N);
            end
            d_gate = 1'b1; e_gate = 1'b1;
            cyc();
            n_vec++; if (s_idle !== 1'b1)
                begin n_err++; $display("FAIL stream%0d_end_idle: got %b want 1", mode, s_idle); end
            D_q.delete(); E_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] dv[2*N];
        logic [31:0] ev[2*N];
        for (int i = 0; i < 2 * N; i++) begin
            dv[i] = $urandom; ev[i] = $urandom;
            D_q.push_back(dv[i]); E_q.push_back(ev[i]);
        end
        d_gate = 1'b1; e_gate = 1'b1; ap_continue = 1'b1;
        ap_start = 1'b1;
        cyc();
        for (int inv = 0; inv < 2; inv++) begin
            for (int i = 0; i < N; i++) begin
                cyc();
                n_vec++; if (s_we !== 1'b1 || s_addr !== 3'(i) || s_d0 !== exp_sum(dv[inv*N+i], ev[inv*N+i]))
                    begin n_err++; $display("FAIL b2b_write[%0d][%0d]: we=%b addr=%0d data=%h want addr=%0d data=%h", inv, i, s_we, s_addr, s_d0, i, exp_sum(dv[inv*N+i], ev[inv*N+i])); end
            end
            if (inv == 1) ap_start = 1'b0;
            cyc();
            n_vec++; if (s_done !== 1'b1)
                begin n_err++; $display("FAIL b2b_done[%0d]: got %b want 1", inv, s_done); end
            cyc();
            n_vec++; if (s_idle !== 1'b1 || s_we !== 1'b0)
                begin n_err++; $display("FAIL b2b_gap[%0d]: idle=%b we=%b want 1 0", inv, s_idle, s_we); end
        end
        D_q.delete(); E_q.delete();
    endtask

    task automatic test_continue_hold();
        for (int i = 0; i < N; i++) begin
            D_q.push_back($urandom); E_q.push_back($urandom);
        end
        d_gate = 1'b1; e_gate = 1'b1; ap_continue = 1'b0;
        ap_start = 1'b1;
        cyc();
        ap_start = 1'b0;
        for (int i = 0; i < N; i++) cyc();
        n_vec++; if (s_ready !== 1'b1)
            begin n_err++; $display("FAIL hold_ready: got %b want 1", s_ready); end
        for (int i = 0; i < 5; i++) begin
            cyc();
            n_vec++; if (s_done !== 1'b1 || s_idle !== 1'b0)
                begin n_err++; $display("FAIL hold_done[%0d]: done=%b idle=%b want 1 0", i, s_done, s_idle); end
        end
        ap_continue = 1'b1;
        cyc();
        n_vec++; if (s_done !== 1'b1)
            begin n_err++; $display("FAIL hold_release_done: got %b want 1", s_done); end
        cyc();
        n_vec++; if (s_idle !== 1'b1 || s_done !== 1'b0)
            begin n_err++; $display("FAIL hold_release_idle: idle=%b done=%b want 1 0", s_idle, s_done); end
        D_q.delete(); E_q.delete();
    endtask

    task automatic test_overflow();
        logic [31:0] dv[N];
        logic [31:0] ev[N];
        logic ovf_model;
        dv[0] = 32'h7FFF_FFFF; ev[0] = 32'h0000_0001;
        dv[1] = 32'h8000_0000; ev[1] = 32'h8000_0000;
        dv[2] = 32'h8000_0000; ev[2] = 32'hFFFF_FFFF;
        for (int i = 3; i < N; i++) begin dv[i] = $urandom; ev[i] = $urandom; end
        for (int i = 0; i < N; i++) begin D_q.push_back(dv[i]); E_q.push_back(ev[i]); end
        d_gate = 1'b1; e_gate = 1'b1; ap_continue = 1'b1;
        ovf_model = 1'b0;
        ap_start = 1'b1;
        cyc();
        ap_start = 1'b0;
        for (int i = 0; i < N; i++) begin
            cyc();
            n_vec++; if (s_ovf !== ovf_model)
                begin n_err++; $display("FAIL ovf_flag_run[%0d]: got %b want %b", i, s_ovf, ovf_model); end
            n_vec++; if (s_d0 !== exp_sum(dv[i], ev[i]))
                begin n_err++; $display("FAIL ovf_sum[%0d]: got %h want %h", i, s_d0, exp_sum(dv[i], ev[i])); end
            if (i == 0) begin
`ifdef JOIN_STORE_SAT_EN
                n_vec++; if (s_d0 !== 32'h7FFF_FFFF) begin n_err++; $display("FAIL ovf_first: got %h want 7fffffff", s_d0); end
`else
                n_vec++; if (s_d0 !== 32'h8000_0000) begin n_err++; $display("FAIL ovf_first: got %h want 80000000", s_d0); end
`endif
            end
            ovf_model = ovf_model | exp_ovf(dv[i], ev[i]);
        end
        cyc();
        cyc();
        n_vec++; if (s_ovf !== ovf_model)
            begin n_err++; $display("FAIL ovf_sticky_idle: got %b want %b", s_ovf, ovf_model); end
        // next start clears the flag; zero pairs cannot overflow
        for (int i = 0; i < N; i++) begin D_q.push_back(32'h0); E_q.push_back(32'h0); end
        ap_start = 1'b1;
        cyc();
        n_vec++; if (s_ovf !== ovf_model)
            begin n_err++; $display("FAIL ovf_before_start: got %b want %b", s_ovf, ovf_model); end
        ap_start = 1'b0;
        ovf_model = 1'b0;
        cyc();
        n_vec++; if (s_ovf !== ovf_model)
            begin n_err++; $display("FAIL ovf_cleared: got %b want %b", s_ovf, ovf_model); end
        for (int i = 1; i < N; i++) cyc();
        cyc();
        cyc();
        D_q.delete(); E_q.delete();
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] dv[N];
        logic [31:0] ev[N];
        for (int i = 0; i < N; i++) begin
            D_q.push_back($urandom); E_q.push_back($urandom);
        end
        d_gate = 1'b1; e_gate = 1'b1; ap_continue = 1'b1;
        ap_start = 1'b1;
        cyc();
        ap_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_vec++; if (s_addr !== 3'(i) || s_we !== 1'b1)
                begin n_err++; $display("FAIL midrst_pre_write[%0d]: addr=%0d we=%b want %0d 1", i, s_addr, s_we, i); end
        end
        #2;
        ap_rst_n = 1'b0;
        #1;
        n_vec++; if (ap_idle !== 1'b1 || D_read !== 1'b0 || E_read !== 1'b0 || F_ce0 !== 1'b0 || F_we0 !== 1'b0 || ap_ready !== 1'b0 || ap_done !== 1'b0)
            begin n_err++; $display("FAIL midrst_async: idle=%b rd=%b/%b ce=%b we=%b rdy=%b done=%b want 1 0/0 0 0 0 0", ap_idle, D_read, E_read, F_ce0, F_we0, ap_ready, ap_done); end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        D_q.delete(); E_q.delete();
        for (int i = 0; i < N; i++) begin
            dv[i] = $urandom; ev[i] = $urandom;
            D_q.push_back(dv[i]); E_q.push_back(ev[i]);
        end
        ap_start = 1'b1;
        cyc();
        ap_start = 1'b0;
        for (int i = 0; i < N; i++) begin
            cyc();
            n_vec++; if (s_addr !== 3'(i) || s_d0 !== exp_sum(dv[i], ev[i]))
                begin n_err++; $display("FAIL midrst_rewrite[%0d]: addr=%0d data=%h want %0d %h", i, s_addr, s_d0, i, exp_sum(dv[i], ev[i])); end
        end
        cyc();
        n_vec++; if (s_done !== 1'b1)
            begin n_err++; $display("FAIL midrst_done: got %b want 1", s_done); end
        cyc();
        D_q.delete(); E_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_preload();
        test_stream(0, 2);
        test_stream(1, 3);
        test_back_to_back();
        test_continue_hold();
        test_overflow();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/join_store_stage.md
Name: join_store_stage

Overview:
- Terminal stage of the toy dataflow pipeline. Consumes the two parallel 32-bit FIFO streams produced by the branch stages (stream D from the B path, stream E from the C path).
- Adds each D/E element pair and writes the result to output RAM F through a single-port write interface.
- Uses the standard ap_ctrl handshake (ap_start/ap_done/ap_idle/ap_ready/ap_continue). In the dataflow top, ap_start comes from the start-token FIFO empty_n, and ap_done drives the top-level ap_done.

Parameters:
- DATA_W, 32, width of FIFO data and RAM words.
- ADDR_W, 3, RAM address width.
- N_ELEM, 8, elements per invocation. Legal range is 1..2^ADDR_W.

Ports:
- ap_clk  in  1  clock, rising edge.
- ap_rst_n  in  1  reset; asynchronous assert, active-low.
- ap_start  in  1  start request.
- ap_continue  in  1  permission to leave DONE.
- ap_done  out  1  invocation complete.
- ap_idle  out  1  block idle.
- ap_ready  out  1  last input pair consumed.
- D_dout  in  DATA_W  head of FIFO D.
- D_empty_n  in  1  FIFO D non-empty.
- D_read  out  1  pop FIFO D.
- E_dout  in  DATA_W  head of FIFO E.
- E_empty_n  in  1  FIFO E non-empty.
- E_read  out  1  pop FIFO E.
- F_address0  out  ADDR_W  RAM address.
- F_ce0  out  1  RAM enable.
- F_we0  out  1  RAM write enable.
- F_d0  out  DATA_W  RAM write data.
- ovf_flag  out  1  sticky overflow indicator (see Optional Feature).

Behaviour:
- Reset (ap_rst_n=0, asynchronous):
  - state=IDLE, idx=0, ovf_flag=0.
  - ap_idle=1; every other output is 0. F_address0 and F_d0 are 0 whenever F_ce0=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - ap_idle=1.
  - ap_start=1 at an edge: idx<=0, state<=RUN, ovf_flag<=0.
- RUN:
  - ap_idle=0.
  - fire = D_empty_n & E_empty_n (combinational).
  - On fire, in the same cycle: D_read=1, E_read=1, F_ce0=1, F_we0=1, F_address0=idx, F_d0=D_dout+E_dout.
  - Without fire: no read and no write. Never pop one FIFO without the other.
  - On fire with idx<N_ELEM-1: idx<=idx+1.
  - On fire with idx==N_ELEM-1: ap_ready=1 that cycle only; state<=DONE; idx<=0.
  - ap_start is ignored while in RUN.
- DONE:
  - ap_done=1, ap_idle=0, no FIFO or RAM activity.
  - ap_continue=1: state<=IDLE at the next edge, so ap_done lasts exactly one cycle when ap_continue is tied high.
  - ap_continue=0: hold DONE with ap_done high.
- Back-to-back invocations: from IDLE with ap_start still high, the next invocation begins one cycle after DONE→IDLE. There is 1 idle cycle between runs.
- Arithmetic:
  - The sum is DATA_W-bit two's complement.
  - Default build: wraps modulo 2^DATA_W.
- Latency:
  - With both FIFOs continuously non-empty, N_ELEM consecutive write cycles occur.
  - ap_done asserts 1 cycle after the last write.
  - Start to done = N_ELEM+1 cycles after the ap_start-sampling edge.
- Reset mid-RUN: returns to IDLE immediately and asynchronously. Partially written F contents are left as-is. FIFOs are not touched by this block.
- N_ELEM=1: ap_ready and the single write occur in the first fire cycle.

Optional Feature:
- Macro: JOIN_STORE_SAT_EN.
- Defined:
  - The sum saturates as signed: to 2^(DATA_W-1)-1 on positive overflow, to -2^(DATA_W-1) on negative overflow.
  - ovf_flag sets on any saturating write and stays set until the next accepted ap_start or reset.
- Undefined: wrap-around sum; ovf_flag is tied 0.

Test Plan:
- Reset with ap_start=0 → ap_idle=1; all other outputs 0; no reads.
- N_ELEM=8, both FIFOs preloaded with D=i and E=10*i for i=0..7, pulse ap_start → F[i]=11*i written at addresses 0..7 on 8 consecutive cycles; ap_ready with address 7; ap_done the next cycle.
- D available every cycle, E available only every 3rd cycle → writes only on cycles where both are non-empty; D_read never asserts without E_read; final F matches D+E in order.
- ap_continue=0 after completion → ap_done held high for 5 cycles; raising ap_continue → IDLE, ap_idle=1 on the next cycle.
- D=0x7FFFFFFF, E=1: default build → F_d0=0x80000000 and ovf_flag=0; with JOIN_STORE_SAT_EN → F_d0=0x7FFFFFFF and ovf_flag=1 until the next start.
- ap_rst_n pulled low after the 3rd write → immediate IDLE with all strobes 0; a new ap_start rewrites from address 0.
